// File: rtl/window_spill_fill_ctrl.sv
// Window sequencer for a 4-window SPARC register file: owns CWP/WIM, runs SAVE/RESTORE,
// and spills/fills the 16 windowed registers (r16-r31) through a handshaked memory port.
module window_spill_fill_ctrl #(
  parameter logic [31:0] SPILL_BASE = 32'h0000_1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Save,
  input  logic        Restore,
  output logic [1:0]  CWP,
  output logic [3:0]  WIM,
  output logic        Busy,
  output logic        Ovf,
  output logic        Unf,
  output logic [1:0]  RF_CWP,
  output logic [4:0]  RF_RA,
  output logic [4:0]  RF_RC,
  output logic        RF_RFE,
  output logic [31:0] RF_Rin,
  input  logic [31:0] RF_Aout,
  output logic        Mem_Req,
  output logic        Mem_WE,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  input  logic [31:0] Mem_RData,
  input  logic        Mem_Ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPILL   = 3'd1,
    FILL_RD = 3'd2,
    FILL_WR = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cwp_q, cwp_d;
  logic [3:0]  wim_q, wim_d;
  logic [1:0]  w_q, w_d;
  logic [1:0]  n_q, n_d;
  logic [3:0]  i_q, i_d;
  logic        spill_q, spill_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [31:0] rin_q, rin_d;

  logic [1:0]  save_n;
  logic [1:0]  restore_n;
  logic [31:0] slot_addr;

  assign save_n    = cwp_q - 2'd1;
  assign restore_n = cwp_q + 2'd1;
  // Each window owns a 64-byte slot; word i of the slot holds r(16+i).
  assign slot_addr = SPILL_BASE + {24'd0, w_q, 6'd0} + {26'd0, i_q, 2'd0};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cwp_q   <= 2'd0;
      wim_q   <= 4'b0010;
      w_q     <= 2'd0;
      n_q     <= 2'd0;
      i_q     <= 4'd0;
      spill_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      rin_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cwp_q   <= cwp_d;
      wim_q   <= wim_d;
      w_q     <= w_d;
      n_q     <= n_d;
      i_q     <= i_d;
      spill_q <= spill_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      rin_q   <= rin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cwp_d   = cwp_q;
    wim_d   = wim_q;
    w_d     = w_q;
    n_d     = n_q;
    i_d     = i_q;
    spill_d = spill_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    rin_d   = rin_q;
    case (state_q)
      IDLE: begin
        if (Save) begin
          if (wim_q[save_n]) begin
            n_d     = save_n;
            w_d     = save_n - 2'd1;
            spill_d = 1'b1;
            ovf_d   = 1'b1;
            i_d     = 4'd0;
            state_d = SPILL;
          end else begin
            cwp_d = save_n;
          end
        end else if (Restore) begin
          if (wim_q[restore_n]) begin
            n_d     = restore_n;
            w_d     = restore_n;
            spill_d = 1'b0;
            unf_d   = 1'b1;
            i_d     = 4'd0;
            state_d = FILL_RD;
          end else begin
            cwp_d = restore_n;
          end
        end
      end
      SPILL: begin
        if (Mem_Ack) begin
          if (i_q == 4'd15) begin
            state_d = COMMIT;
          end else begin
            i_d = i_q + 4'd1;
          end
        end
      end
      FILL_RD: begin
        if (Mem_Ack) begin
          rin_d   = Mem_RData;
          state_d = FILL_WR;
        end
      end
      FILL_WR: begin
        if (i_q == 4'd15) begin
          state_d = COMMIT;
        end else begin
          i_d     = i_q + 4'd1;
          state_d = FILL_RD;
        end
      end
      COMMIT: begin
        // CWP/WIM change only here, so an aborted transfer leaves them untouched.
        cwp_d   = n_q;
        wim_d   = spill_q ? (4'b0001 << w_q) : (4'b0001 << (n_q + 2'd1));
        i_d     = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state_q != IDLE);
    RF_CWP    = cwp_q;
    RF_RA     = 5'd0;
    RF_RC     = 5'd0;
    RF_RFE    = 1'b1;
    Mem_Req   = 1'b0;
    Mem_WE    = 1'b0;
    Mem_Addr  = 32'd0;
    Mem_WData = 32'd0;
    case (state_q)
      SPILL: begin
        RF_CWP    = w_q;
        RF_RA     = {1'b1, i_q};
        Mem_Req   = 1'b1;
        Mem_WE    = 1'b1;
        Mem_Addr  = slot_addr;
        Mem_WData = RF_Aout;
      end
      FILL_RD: begin
        RF_CWP   = w_q;
        Mem_Req  = 1'b1;
        Mem_Addr = slot_addr;
      end
      FILL_WR: begin
        RF_CWP = w_q;
        RF_RC  = {1'b1, i_q};
        RF_RFE = 1'b0;
      end
      default: ;
    endcase
  end

  assign CWP    = cwp_q;
  assign WIM    = wim_q;
  assign Ovf    = ovf_q;
  assign Unf    = unf_q;
  assign RF_Rin = rin_q;

endmodule
